usb_keyboard_typer: RTL and testbench

USB_KEYBOARD_TYPER -- requirements
Module: usb_keyboard_typer

---
 rtl/usb_keyboard_typer.sv | 132 +++++++++++++
 tb/tb_usb_keyboard_typer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/usb_keyboard_typer.sv
// ASCII-to-USB-HID typer: buffers ASCII bytes in a FIFO and emits one key report per
// supported character, spacing reports by a programmable idle gap.
module usb_keyboard_typer #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [23:0] GAP_CYCLES = 24'd3_000_000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  ascii_data,
    input  logic        ascii_valid,
    output logic        ascii_ready,
    output logic [15:0] key_value,
    output logic        key_request,
    output logic        busy
);

    localparam int             AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    DEPTH_L = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {
        IDLE,
        POP,
        MAP,
        FIRE,
        GAP
    } state_t;

    state_t         state, next_state;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic [7:0]     char_reg;
    logic [23:0]    gap_cnt;
    logic           push, pop;
    logic           map_ok;
    logic [15:0]    map_val;

    assign ascii_ready = (count != DEPTH_L);
    assign push        = ascii_valid && ascii_ready;
    assign pop         = (state == POP);
    assign busy        = (state != IDLE) || (count != '0);

    // Storage has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ascii_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        map_ok  = 1'b1;
        map_val = 16'h0000;
        if (char_reg >= 8'h61 && char_reg <= 8'h7A) begin
            map_val = {8'h00, 8'h04 + (char_reg - 8'h61)};
        end else if (char_reg >= 8'h41 && char_reg <= 8'h5A) begin
            map_val = {8'h02, 8'h04 + (char_reg - 8'h41)};
        end else if (char_reg >= 8'h31 && char_reg <= 8'h39) begin
            map_val = {8'h00, 8'h1E + (char_reg - 8'h31)};
        end else begin
            case (char_reg)
                8'h30:   map_val = 16'h0027;
                8'h0A:   map_val = 16'h0028;
                8'h08:   map_val = 16'h002A;
                8'h09:   map_val = 16'h002B;
                8'h20:   map_val = 16'h002C;
                8'h2D:   map_val = 16'h002D;
                8'h2C:   map_val = 16'h0036;
                8'h2E:   map_val = 16'h0037;
                default: map_ok  = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A finished gap with more bytes queued goes straight to POP so that
    // back-to-back reports are spaced exactly GAP_CYCLES+3 apart.
    always_comb begin
        next_state  = state;
        key_request = 1'b0;
        case (state)
            IDLE: if (count != '0) next_state = POP;
            POP:  next_state = MAP;
            MAP:  next_state = map_ok ? FIRE : IDLE;
            FIRE: begin
                key_request = 1'b1;
                next_state  = GAP;
            end
            GAP:  if (gap_cnt == 24'd0) next_state = (count != '0) ? POP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            char_reg  <= 8'h00;
            key_value <= 16'h0000;
            gap_cnt   <= 24'd0;
        end else begin
            if (state == POP) char_reg <= mem[rd_ptr];
            if (state == MAP && map_ok) key_value <= map_val;
            if (state == FIRE) begin
                gap_cnt <= GAP_CYCLES - 24'd1;
            end else if (state == GAP && gap_cnt != 24'd0) begin
                gap_cnt <= gap_cnt - 24'd1;
            end
        end
    end

endmodule

// File: tb/tb_usb_keyboard_typer.sv
// Directed bench for usb_keyboard_typer: one instance with a short gap for timing and
// mapping, one with a shallow FIFO and long gap for backpressure.
module tb_usb_keyboard_typer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  a_data = 8'h00, b_data = 8'h00;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [15:0] a_key_value, b_key_value;
    logic        a_key_request, b_key_request;
    logic        a_busy, b_busy;

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          a_cyc[$];
    logic [15:0] a_val[$];
    logic [15:0] b_val[$];
    logic [7:0]  stim_q[$];
    logic [15:0] exp_q[$];
    bit          saw_low_b = 0;
    int          accepted_at_low = -1;

    usb_keyboard_typer #(.FIFO_DEPTH(16), .GAP_CYCLES(24'd8)) dut_a (
        .clk(clk), .rstn(rstn),
        .ascii_data(a_data), .ascii_valid(a_valid), .ascii_ready(a_ready),
        .key_value(a_key_value), .key_request(a_key_request), .busy(a_busy)
    );

    usb_keyboard_typer #(.FIFO_DEPTH(4), .GAP_CYCLES(24'd100)) dut_b (
        .clk(clk), .rstn(rstn),
        .ascii_data(b_data), .ascii_valid(b_valid), .ascii_ready(b_ready),
        .key_value(b_key_value), .key_request(b_key_request), .busy(b_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse logs, sampled mid-cycle; cyc here equals the number of edges seen so far.
    always @(negedge clk) begin
        if (a_key_request) begin
            a_cyc.push_back(cyc);
            a_val.push_back(a_key_value);
        end
        if (b_key_request) b_val.push_back(b_key_value);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] a_cyc_at(int i);
        return (i < a_cyc.size()) ? a_cyc[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] a_val_at(int i);
        return (i < a_val.size()) ? {16'h0, a_val[i]} : 32'hFFFF_FFFF;
    endfunction

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Presents stim_q with valid held high; first_edge is the edge that accepted byte 0.
    task automatic applyStimulus(input bit use_b, output int first_edge);
        int timeout;
        int accepted;
        logic rdy;
        first_edge = -1;
        accepted   = 0;
        @(negedge clk);
        foreach (stim_q[i]) begin
            if (use_b) begin b_data = stim_q[i]; b_valid = 1'b1; end
            else       begin a_data = stim_q[i]; a_valid = 1'b1; end
            timeout = 0;
            forever begin
                rdy = use_b ? b_ready : a_ready;
                if (rdy) begin
                    if (i == 0) first_edge = cyc + 1;
                    accepted++;
                    @(negedge clk);
                    break;
                end
                if (use_b && !saw_low_b) begin
                    saw_low_b       = 1;
                    accepted_at_low = accepted;
                end
                @(negedge clk);
                timeout++;
                if (timeout > 400) begin
                    checkOutput("push_timeout", 0, 1);
                    break;
                end
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    initial begin
        int n;

        repeat (2) @(negedge clk);
        checkOutput("rst_key_value", a_key_value, 16'h0000);
        checkOutput("rst_key_request", a_key_request, 0);
        checkOutput("rst_busy", a_busy, 0);
        checkOutput("rst_ready", a_ready, 1);
        checkOutput("rst_ready_b", b_ready, 1);
        rstn = 1'b1;

        // Single 'a': pulse 3 edges after acceptance, busy falls 9 cycles after pulse.
        stim_q = '{8'h61};
        applyStimulus(0, n);
        waitUntil(n + 11);
        checkOutput("a_busy_gap_end", a_busy, 1);
        waitUntil(n + 12);
        checkOutput("a_busy_fall", a_busy, 0);
        waitUntil(n + 20);
        checkOutput("a_pulses", a_cyc.size(), 1);
        checkOutput("a_latency", a_cyc_at(0), n + 3);
        checkOutput("a_value", a_val_at(0), 16'h0004);

        // "A1\n" back-to-back: pulses exactly 11 cycles apart.
        a_cyc.delete(); a_val.delete();
        stim_q = '{8'h41, 8'h31, 8'h0A};
        applyStimulus(0, n);
        waitUntil(n + 45);
        checkOutput("A1nl_pulses", a_cyc.size(), 3);
        checkOutput("A1nl_t0", a_cyc_at(0), n + 3);
        checkOutput("A1nl_t1", a_cyc_at(1), n + 14);
        checkOutput("A1nl_t2", a_cyc_at(2), n + 25);
        checkOutput("A1nl_v0", a_val_at(0), 16'h0204);
        checkOutput("A1nl_v1", a_val_at(1), 16'h001E);
        checkOutput("A1nl_v2", a_val_at(2), 16'h0028);

        // Unsupported 0x7E ahead of 'z' costs three cycles.
        a_cyc.delete(); a_val.delete();
        stim_q = '{8'h7E, 8'h7A};
        applyStimulus(0, n);
        waitUntil(n + 25);
        checkOutput("skip_pulses", a_cyc.size(), 1);
        checkOutput("skip_latency", a_cyc_at(0), n + 6);
        checkOutput("skip_value", a_val_at(0), 16'h001D);

        // Special keys and range boundaries; trailing unsupported bytes leave key_value alone.
        a_cyc.delete(); a_val.delete();
        stim_q = '{8'h30, 8'h08, 8'h09, 8'h20, 8'h2D, 8'h2C, 8'h2E, 8'h5A, 8'h39,
                   8'h60, 8'h7B, 8'h40, 8'h5B, 8'hFF};
        exp_q  = '{16'h0027, 16'h002A, 16'h002B, 16'h002C, 16'h002D, 16'h0036,
                   16'h0037, 16'h021D, 16'h0026};
        applyStimulus(0, n);
        waitUntil(n + 200);
        checkOutput("map_pulses", a_cyc.size(), exp_q.size());
        foreach (exp_q[i]) checkOutput($sformatf("map_v%0d", i), a_val_at(i), {16'h0, exp_q[i]});
        checkOutput("map_hold", a_key_value, 16'h0026);
        checkOutput("map_idle", a_busy, 0);

        // Shallow FIFO backpressure: ready drops once 4 bytes are held (5 accepted, 1 popped).
        stim_q = '{8'h61, 8'h62, 8'h63, 8'h2E, 8'h31, 8'h32};
        exp_q  = '{16'h0004, 16'h0005, 16'h0006, 16'h0037, 16'h001E, 16'h001F};
        applyStimulus(1, n);
        checkOutput("fifo_ready_low", saw_low_b, 1);
        checkOutput("fifo_low_at", accepted_at_low, 5);
        waitUntil(n + 700);
        checkOutput("fifo_pulses", b_val.size(), 6);
        foreach (exp_q[i]) checkOutput($sformatf("fifo_v%0d", i),
                                       (i < b_val.size()) ? {16'h0, b_val[i]} : 32'hFFFF_FFFF,
                                       {16'h0, exp_q[i]});

        // Reset during GAP with three bytes still queued.
        a_cyc.delete(); a_val.delete();
        stim_q = '{8'h62, 8'h63, 8'h64, 8'h65};
        applyStimulus(0, n);
        waitUntil(n + 6);
        checkOutput("mid_busy_pre", a_busy, 1);
        rstn = 1'b0;
        #1;
        checkOutput("mid_key_value", a_key_value, 16'h0000);
        checkOutput("mid_key_request", a_key_request, 0);
        checkOutput("mid_busy", a_busy, 0);
        checkOutput("mid_ready", a_ready, 1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        a_cyc.delete(); a_val.delete();
        repeat (40) @(negedge clk);
        checkOutput("post_rst_quiet", a_cyc.size(), 0);
        stim_q = '{8'h71};
        applyStimulus(0, n);
        waitUntil(n + 15);
        checkOutput("post_rst_pulses", a_cyc.size(), 1);
        checkOutput("post_rst_latency", a_cyc_at(0), n + 3);
        checkOutput("post_rst_value", a_val_at(0), 16'h0014);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
